// File: rtl/pcpu_mem_harness.sv
// Memory/stimulus harness for PIPE_CPU: instruction ROM, data RAM with configurable read latency,
// a valid/ready program loader, and a run controller that detects HALT and checks one result word.
module pcpu_mem_harness #(
   parameter int          ADDR_W  = 8,
   parameter int          DATA_W  = 16,
   parameter int          RD_LAT  = 3,
   parameter logic [4:0]  HALT_OP = 5'b00001,
   parameter int          DRAIN   = 4,
   parameter int          TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic              ld_sel,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              run_req,
   input  logic              abort,
   input  logic [ADDR_W-1:0] chk_addr,
   input  logic [DATA_W-1:0] chk_expect,
   output logic              cpu_enable,
   output logic              cpu_start,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_datain,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_we,
   input  logic [DATA_W-1:0] d_dataout,
   output logic [DATA_W-1:0] d_datain,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [15:0]       cycles
);

   localparam int DEPTH   = 1 << ADDR_W;
   localparam int DRAIN_W = (DRAIN < 2) ? 1 : $clog2(DRAIN + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_RUN, S_DRAIN, S_CHECK, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [DRAIN_W-1:0]  drain_q, drain_d;
   logic [15:0]         cycles_q, cycles_d;
   logic                done_q, done_d;
   logic                pass_q, pass_d;
   logic                timeout_q, timeout_d;
   logic [DATA_W-1:0]   i_datain_q;
   logic [DATA_W-1:0]   d_hold_q;
   logic [RD_LAT-1:0]   rd_vld_q;
   logic [DATA_W-1:0]   rd_dat_q [RD_LAT];

   logic [DATA_W-1:0]   imem_q [DEPTH];
   logic [DATA_W-1:0]   dmem_q [DEPTH];

   logic loader_open, ld_fire, fetch_en, mem_active, cpu_wr, rd_issue, halt_hit, tmo_hit;

   assign loader_open = (state_q == S_IDLE) || (state_q == S_DONE);
   assign ld_fire     = ld_valid && loader_open;
   assign fetch_en    = (state_q == S_START) || (state_q == S_RUN) || (state_q == S_DRAIN);
   assign mem_active  = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign cpu_wr      = mem_active && d_we;
   assign rd_issue    = mem_active && !d_we;
   assign halt_hit    = (i_datain_q[DATA_W-1 -: 5] == HALT_OP);
   assign tmo_hit     = (cycles_q == 16'(TIMEOUT - 1));

   // Arrays carry no reset so a loaded program survives rst_n.
   always_ff @(posedge clk) begin
      if (ld_fire && !ld_sel) imem_q[ld_addr] <= ld_data;
   end

   always_ff @(posedge clk) begin
      if (ld_fire && ld_sel) dmem_q[ld_addr] <= ld_data;
      else if (cpu_wr)       dmem_q[d_addr]  <= d_dataout;
   end

   always_comb begin
      state_d   = state_q;
      drain_d   = drain_q;
      cycles_d  = cycles_q;
      done_d    = done_q;
      pass_d    = pass_q;
      timeout_d = timeout_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (run_req) begin
               state_d   = S_START;
               cycles_d  = '0;
               done_d    = 1'b0;
               pass_d    = 1'b0;
               timeout_d = 1'b0;
            end
         end
         S_START: begin
            state_d = abort ? S_DONE : S_RUN;
            done_d  = abort;
         end
         S_RUN: begin
            if (cycles_q != 16'hFFFF) cycles_d = cycles_q + 16'd1;
            if (abort) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else if (tmo_hit) begin
               // Timeout wins over a HALT seen in the same cycle; count freezes at the limit.
               state_d   = S_DONE;
               done_d    = 1'b1;
               timeout_d = 1'b1;
               cycles_d  = cycles_q;
            end else if (halt_hit) begin
               state_d = S_DRAIN;
               drain_d = DRAIN_W'(DRAIN);
            end
         end
         S_DRAIN: begin
            if (abort) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else if (drain_q == '0) begin
               state_d = S_CHECK;
            end else begin
               drain_d = drain_q - DRAIN_W'(1);
            end
         end
         S_CHECK: begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = (dmem_q[chk_addr] == chk_expect);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         drain_q    <= '0;
         cycles_q   <= '0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         timeout_q  <= 1'b0;
         i_datain_q <= '0;
         d_hold_q   <= '0;
         rd_vld_q   <= '0;
         for (int i = 0; i < RD_LAT; i++) rd_dat_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         drain_q   <= drain_d;
         cycles_q  <= cycles_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         timeout_q <= timeout_d;
         d_hold_q  <= d_datain;
         if (fetch_en) i_datain_q <= imem_q[i_addr];
         rd_vld_q[0] <= rd_issue;
         if (rd_issue) rd_dat_q[0] <= dmem_q[d_addr];
         for (int i = 1; i < RD_LAT; i++) begin
            rd_vld_q[i] <= rd_vld_q[i-1];
            rd_dat_q[i] <= rd_dat_q[i-1];
         end
      end
   end

   // Read data appears RD_LAT cycles after issue and is held until the next read lands.
   assign d_datain   = rd_vld_q[RD_LAT-1] ? rd_dat_q[RD_LAT-1] : d_hold_q;
   assign i_datain   = i_datain_q;
   assign ld_ready   = loader_open;
   assign busy       = !loader_open;
   assign cpu_start  = (state_q == S_START);
   assign cpu_enable = fetch_en || (state_q == S_CHECK);
   assign done       = done_q;
   assign pass       = pass_q;
   assign timeout    = timeout_q;
   assign cycles     = cycles_q;

endmodule

// File: tb/tb_pcpu_mem_harness.sv
// Directed bench for pcpu_mem_harness: two builds (RD_LAT 1 and 4, TIMEOUT 64) share one stimulus.
module tb_pcpu_mem_harness;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ld_valid, ld_sel, run_req, abort, d_we;
   logic [7:0]  ld_addr, chk_addr, i_addr, d_addr;
   logic [15:0] ld_data, chk_expect, d_dataout;

   logic        a_ld_ready, a_cpu_enable, a_cpu_start, a_busy, a_done, a_pass, a_timeout;
   logic [15:0] a_i_datain, a_d_datain, a_cycles;
   logic        b_ld_ready, b_cpu_enable, b_cpu_start, b_busy, b_done, b_pass, b_timeout;
   logic [15:0] b_i_datain, b_d_datain, b_cycles;

   int n_chk  = 0;
   int n_fail = 0;
   logic [15:0] v0, v1;

   always #5 clk = ~clk;

   pcpu_mem_harness #(.RD_LAT(1), .TIMEOUT(64)) u_dut_l1 (
      .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(a_ld_ready), .ld_sel(ld_sel),
      .ld_addr(ld_addr), .ld_data(ld_data), .run_req(run_req), .abort(abort),
      .chk_addr(chk_addr), .chk_expect(chk_expect), .cpu_enable(a_cpu_enable),
      .cpu_start(a_cpu_start), .i_addr(i_addr), .i_datain(a_i_datain), .d_addr(d_addr),
      .d_we(d_we), .d_dataout(d_dataout), .d_datain(a_d_datain), .busy(a_busy),
      .done(a_done), .pass(a_pass), .timeout(a_timeout), .cycles(a_cycles));

   pcpu_mem_harness #(.RD_LAT(4), .TIMEOUT(64)) u_dut_l4 (
      .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(b_ld_ready), .ld_sel(ld_sel),
      .ld_addr(ld_addr), .ld_data(ld_data), .run_req(run_req), .abort(abort),
      .chk_addr(chk_addr), .chk_expect(chk_expect), .cpu_enable(b_cpu_enable),
      .cpu_start(b_cpu_start), .i_addr(i_addr), .i_datain(b_i_datain), .d_addr(d_addr),
      .d_we(d_we), .d_dataout(d_dataout), .d_datain(b_d_datain), .busy(b_busy),
      .done(b_done), .pass(b_pass), .timeout(b_timeout), .cycles(b_cycles));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic sel, input logic [7:0] a, input logic [15:0] d);
      ld_valid = 1'b1; ld_sel = sel; ld_addr = a; ld_data = d;
      step();
      ld_valid = 1'b0;
   endtask

   task automatic start_run();
      run_req = 1'b1;
      step();
      run_req = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!a_done && n < budget) begin
         step();
         n++;
      end
      chk("done_wait", a_done, 1);
   endtask

   // Read 'a' now, then fall back to reading addr 6 (0BAD); 'v' must land exactly RD_LAT cycles later.
   task automatic rd_probe(input logic [7:0] a, input logic [15:0] v);
      d_we = 1'b0; d_addr = a;
      for (int k = 1; k <= 4; k++) begin
         step();
         if (k == 1) d_addr = 8'd6;
         chk("rd_lat1", a_d_datain, (k == 1) ? v : 16'h0BAD);
         chk("rd_lat4", b_d_datain, (k == 4) ? v : 16'h0BAD);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1; ld_valid = 0; ld_sel = 0; ld_addr = 0; ld_data = 0; run_req = 0; abort = 0;
      chk_addr = 0; chk_expect = 0; i_addr = 0; d_addr = 0; d_we = 0; d_dataout = 0;
      #3 rst_n = 1'b0;
      repeat (2) step();
      chk("rst_ctl", {a_ld_ready, a_busy, a_done, a_pass, a_timeout, a_cpu_enable, a_cpu_start}, 7'b1000000);
      chk("rst_cycles", a_cycles, 0);
      chk("rst_data", {a_i_datain, a_d_datain, b_d_datain}, 48'h0);
      rst_n = 1'b1;
      step();

      // Run 1: all-NOP program must time out at cycles == TIMEOUT-1.
      for (int i = 0; i < 256; i++) load(1'b0, 8'(i), 16'h0000);
      load(1'b1, 8'd5, 16'h1234);
      load(1'b1, 8'd6, 16'h0BAD);
      load(1'b1, 8'd7, 16'h0000);
      d_addr = 8'd6;
      start_run();
      chk("start_ctl", {a_cpu_start, a_cpu_enable, a_busy, a_ld_ready}, 4'b1110);
      step();
      chk("run_cyc0", a_cycles, 0);
      chk("run_ctl", {a_cpu_start, a_cpu_enable}, 2'b01);
      ld_valid = 1'b1; ld_sel = 1'b1; ld_addr = 8'd5; ld_data = 16'hFFFF; run_req = 1'b1;
      chk("ld_blocked", a_ld_ready, 0);
      step();
      ld_valid = 1'b0; run_req = 1'b0;
      repeat (4) step();
      chk("rd_pre_l1", a_d_datain, 16'h0BAD);
      chk("rd_pre_l4", b_d_datain, 16'h0BAD);
      rd_probe(8'd5, 16'h1234);
      step();
      d_we = 1'b1; d_addr = 8'd7; d_dataout = 16'h55AA;
      step();
      rd_probe(8'd7, 16'h55AA);
      wait_done(100);
      chk("tmo_flags", {a_done, a_timeout, a_pass, a_busy, a_cpu_enable, a_ld_ready}, 6'b110001);
      chk("tmo_cycles", a_cycles, 63);

      // Run 2: abort mid-run after a restart.
      start_run();
      step();
      chk("restart_cyc", a_cycles, 0);
      chk("restart_done", a_done, 0);
      repeat (3) step();
      chk("cyc_count", a_cycles, 3);
      chk("busy_ldrdy", {a_busy, a_ld_ready}, 2'b10);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_flags", {a_done, a_pass, a_timeout, a_busy}, 4'b1000);

      // Run 3: program with a CPU model that reads, adds and stores the result.
      load(1'b0, 8'd0, 16'h1080);
      load(1'b0, 8'd1, 16'h1101);
      load(1'b0, 8'd2, 16'h4312);
      load(1'b0, 8'd3, 16'h1B02);
      load(1'b0, 8'd4, 16'h0800);
      load(1'b1, 8'd0, 16'h00AB);
      load(1'b1, 8'd1, 16'h3C00);
      load(1'b1, 8'd2, 16'h0000);
      chk_addr = 8'd2; chk_expect = 16'h3CAB; i_addr = 8'd0; d_addr = 8'd0;
      start_run();
      step();
      chk("fetch0", a_i_datain, 16'h1080);
      repeat (5) step();
      v0 = a_d_datain;
      chk("load_gr1", v0, 16'h00AB);
      chk("load_gr1_l4", b_d_datain, 16'h00AB);
      d_addr = 8'd1;
      repeat (5) step();
      v1 = a_d_datain;
      chk("load_gr2", v1, 16'h3C00);
      d_we = 1'b1; d_addr = 8'd2; d_dataout = v0 + v1;
      step();
      d_we = 1'b0; d_addr = 8'd0; i_addr = 8'd4;
      step();
      chk("fetch_halt", a_i_datain, 16'h0800);
      step();
      chk("drain_ctl", {a_busy, a_cpu_enable, a_done}, 3'b110);
      repeat (5) step();
      chk("drain_len_pre", a_done, 0);
      step();
      chk("drain_len", a_done, 1);
      chk("prog_result", {a_pass, a_timeout}, 2'b10);

      // Run 4: wrong expectation must report pass=0.
      chk_expect = 16'h3CAA;
      start_run();
      wait_done(40);
      chk("bad_expect", {a_pass, a_timeout}, 2'b00);

      // Run 5: asynchronous reset while draining; DMEM must survive.
      chk_expect = 16'h3CAB;
      start_run();
      repeat (3) step();
      chk("pre_rst_busy", a_busy, 1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_async", {a_cpu_enable, a_cpu_start, a_busy, a_ld_ready, a_done, a_pass, a_timeout}, 7'b0001000);
      chk("rst_async_cyc", a_cycles, 0);
      step();
      rst_n = 1'b1;
      step();
      start_run();
      wait_done(40);
      chk("mem_kept", {a_pass, a_timeout}, 2'b10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
